// File: rtl/brams_portb_router_if.sv
// Bundle of the command, BRAM port-B and math read-data signals for the port-B router.
// The master side is the surrounding system: it issues commands and owns the BRAM read data.
// The slave side is the router, which drives the BRAM controls and the math read results.
interface brams_portb_router_if #(
    parameter int BRAM_DW  = 64,
    parameter int BRAM_AW  = 10,
    parameter int BRAMS    = 8,
    parameter int ADR_SRC  = 3,
    parameter int RD_PORTS = 2
);
    localparam int SW = $clog2(BRAMS);
    localparam int AS = $clog2(ADR_SRC + 1);

    logic                        cmd_valid;
    logic [ADR_SRC*BRAM_AW-1:0]  math_adr;
    logic [BRAMS*AS-1:0]         adr_sel;
    logic                        math_we;
    logic [SW-1:0]               we_sel;
    logic [RD_PORTS-1:0]         rd_req;
    logic [RD_PORTS*SW-1:0]      rd_sel;
    logic                        err_clr;

    logic [BRAMS*BRAM_AW-1:0]    bram_adr;
    logic [BRAMS-1:0]            bram_we;
    logic [BRAMS-1:0]            bram_en;
    logic [BRAMS*BRAM_DW-1:0]    bram_do;

    logic [RD_PORTS*BRAM_DW-1:0] math_dat;
    logic [RD_PORTS-1:0]         math_dat_vld;
    logic                        err_conflict;

    modport master (
        output cmd_valid, math_adr, adr_sel, math_we, we_sel, rd_req, rd_sel, err_clr,
        output bram_do,
        input  bram_adr, bram_we, bram_en,
        input  math_dat, math_dat_vld, err_conflict
    );

    modport slave (
        input  cmd_valid, math_adr, adr_sel, math_we, we_sel, rd_req, rd_sel, err_clr,
        input  bram_do,
        output bram_adr, bram_we, bram_en,
        output math_dat, math_dat_vld, err_conflict
    );
endinterface

// File: rtl/brams_portb_router_pipe.sv
// Port-B router for a bank of BRAMs.
// One command per cycle selects an address source per BRAM, an optional write target and
// per-port read sources. Read data returns BRAM_LAT+2 cycles after the command: one cycle
// for the registered BRAM controls, BRAM_LAT for the BRAM itself, one for the output register.
// A sticky flag records writes that collide with a same-cycle read or use a zeroed address.
module brams_portb_router_pipe #(
    parameter int BRAM_DW  = 64,
    parameter int BRAM_AW  = 10,
    parameter int BRAMS    = 8,
    parameter int ADR_SRC  = 3,
    parameter int RD_PORTS = 2,
    parameter int BRAM_LAT = 1
) (
    input logic clk,
    input logic rst,
    brams_portb_router_if.slave bus
);
    localparam int SW   = $clog2(BRAMS);
    localparam int AS   = $clog2(ADR_SRC + 1);
    localparam int PIPE = BRAM_LAT + 1;

    logic [BRAMS*BRAM_AW-1:0]    bramAdr_d, bramAdr_q;
    logic [BRAMS-1:0]            bramEn_d, bramEn_q;
    logic [BRAMS-1:0]            bramWe_d, bramWe_q;
    logic [AS-1:0]               srcCode;

    logic                        errSet;
    logic                        errConflict_d, errConflict_q;

    logic [RD_PORTS-1:0]         rdVld_q [PIPE];
    logic [RD_PORTS*SW-1:0]      rdSel_q [PIPE];

    logic [SW-1:0]               outSel;
    logic [RD_PORTS*BRAM_DW-1:0] mathDat_d, mathDat_q;
    logic [RD_PORTS-1:0]         mathVld_d, mathVld_q;

    // Decode the command into per-BRAM address, enable and write strobe; idle cycles keep the address
    always_comb begin
        bramAdr_d = bramAdr_q;
        bramEn_d  = '0;
        bramWe_d  = '0;
        srcCode   = '0;
        if (bus.cmd_valid) begin
            for (int i = 0; i < BRAMS; i++) begin
                srcCode = bus.adr_sel[i*AS +: AS];
                bramAdr_d[i*BRAM_AW +: BRAM_AW] = '0;
                for (int k = 0; k < ADR_SRC; k++) begin
                    if (srcCode == AS'(k)) begin
                        bramAdr_d[i*BRAM_AW +: BRAM_AW] = bus.math_adr[k*BRAM_AW +: BRAM_AW];
                        bramEn_d[i] = 1'b1;
                    end
                end
                if (bus.math_we && (bus.we_sel == SW'(i))) begin
                    bramWe_d[i] = 1'b1;
                    bramEn_d[i] = 1'b1;
                end
                for (int p = 0; p < RD_PORTS; p++) begin
                    if (bus.rd_req[p] && (bus.rd_sel[p*SW +: SW] == SW'(i))) begin
                        bramEn_d[i] = 1'b1;
                    end
                end
            end
        end
    end

    // Detect write/read collisions and writes through a zeroed address; a new hit outranks a clear
    always_comb begin
        errSet = 1'b0;
        if (bus.cmd_valid && bus.math_we) begin
            for (int p = 0; p < RD_PORTS; p++) begin
                if (bus.rd_req[p] && (bus.rd_sel[p*SW +: SW] == bus.we_sel)) begin
                    errSet = 1'b1;
                end
            end
            for (int i = 0; i < BRAMS; i++) begin
                if ((bus.we_sel == SW'(i)) && (32'(bus.adr_sel[i*AS +: AS]) >= ADR_SRC)) begin
                    errSet = 1'b1;
                end
            end
        end
        if (errSet) begin
            errConflict_d = 1'b1;
        end else if (bus.err_clr) begin
            errConflict_d = 1'b0;
        end else begin
            errConflict_d = errConflict_q;
        end
    end

    // Register the BRAM controls and the conflict flag
    always_ff @(posedge clk) begin
        if (rst) begin
            bramAdr_q     <= '0;
            bramEn_q      <= '0;
            bramWe_q      <= '0;
            errConflict_q <= 1'b0;
        end else begin
            bramAdr_q     <= bramAdr_d;
            bramEn_q      <= bramEn_d;
            bramWe_q      <= bramWe_d;
            errConflict_q <= errConflict_d;
        end
    end

    // Carry read requests and their source BRAM alongside the BRAM access until its data is out
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < PIPE; s++) begin
                rdVld_q[s] <= '0;
                rdSel_q[s] <= '0;
            end
        end else begin
            rdVld_q[0] <= bus.cmd_valid ? bus.rd_req : '0;
            rdSel_q[0] <= bus.rd_sel;
            for (int s = 1; s < PIPE; s++) begin
                rdVld_q[s] <= rdVld_q[s-1];
                rdSel_q[s] <= rdSel_q[s-1];
            end
        end
    end

    // Pick each port's word from the BRAM outputs; unknown BRAM indices return zero, idle ports hold
    always_comb begin
        mathDat_d = mathDat_q;
        mathVld_d = rdVld_q[PIPE-1];
        outSel    = '0;
        for (int p = 0; p < RD_PORTS; p++) begin
            if (rdVld_q[PIPE-1][p]) begin
                outSel = rdSel_q[PIPE-1][p*SW +: SW];
                mathDat_d[p*BRAM_DW +: BRAM_DW] = '0;
                for (int i = 0; i < BRAMS; i++) begin
                    if (outSel == SW'(i)) begin
                        mathDat_d[p*BRAM_DW +: BRAM_DW] = bus.bram_do[i*BRAM_DW +: BRAM_DW];
                    end
                end
            end
        end
    end

    // Register the math read data and its single-cycle valid pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            mathDat_q <= '0;
            mathVld_q <= '0;
        end else begin
            mathDat_q <= mathDat_d;
            mathVld_q <= mathVld_d;
        end
    end

    assign bus.bram_adr     = bramAdr_q;
    assign bus.bram_en      = bramEn_q;
    assign bus.bram_we      = bramWe_q;
    assign bus.math_dat     = mathDat_q;
    assign bus.math_dat_vld = mathVld_q;
    assign bus.err_conflict = errConflict_q;
endmodule

// File: tb/tb_brams_portb_router_pipe.sv
// Bench for the port-B router: a table of single-cycle command vectors for the control outputs,
// a one-cycle BRAM model feeding a read scoreboard, and short sequences for latency,
// throughput, reset in flight and conflict flag handling.
module tb_brams_portb_router_pipe;
    localparam int DW  = 64;
    localparam int AW  = 10;
    localparam int NB  = 8;
    localparam int NS  = 3;
    localparam int NP  = 2;
    localparam int LAT = 1;

    typedef struct packed {
        logic               cv;
        logic [2:0][9:0]    madr;
        logic [7:0][1:0]    asel;
        logic               we;
        logic [2:0]         wsel;
        logic [1:0]         rreq;
        logic [1:0][2:0]    rsel;
        logic               clr;
        logic [7:0][9:0]    expAdr;
        logic [7:0]         expEn;
        logic [7:0]         expWe;
        logic               expErr;
    } vec_t;

    typedef struct packed {
        int          due;
        int          port;
        logic [63:0] data;
    } sb_t;

    logic clk;
    logic rst;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    sb_t  sbq [$];
    vec_t vecs [8];
    vec_t v;
    logic [7:0][63:0] bramDoQ = '0;

    brams_portb_router_if bus ();

    brams_portb_router_pipe dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    assign bus.bram_do = bramDoQ;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Cycle counter used to time-stamp expected read results
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [63:0] expWord(input int i, input logic [9:0] a);
        return {8'hA5, 24'(i), 22'd0, a};
    endfunction

    // BRAM model with one cycle of read latency: returns a word tagged with its index and address
    always @(posedge clk) begin
        for (int i = 0; i < NB; i++) begin
            if (bus.bram_en[i] === 1'b1) bramDoQ[i] <= expWord(i, bus.bram_adr[i*AW +: AW]);
        end
    end

    task automatic checkVal(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Compare every read-data pulse against the oldest pending expectation for that port
    always @(negedge clk) begin
        int idx;
        for (int p = 0; p < NP; p++) begin
            if (bus.math_dat_vld[p] === 1'b1) begin
                idx = -1;
                for (int k = 0; k < sbq.size(); k++) begin
                    if (idx < 0 && sbq[k].port == p) idx = k;
                end
                if (idx < 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL rd_unexpected: port %0d got vld=1 want vld=0 (cycle %0d)", p, cyc);
                end else begin
                    checkVal("rd_data", bus.math_dat[p*DW +: DW], sbq[idx].data);
                    checkVal("rd_cycle", cyc, sbq[idx].due);
                    sbq.delete(idx);
                end
            end
        end
        for (int k = sbq.size() - 1; k >= 0; k--) begin
            if (sbq[k].due <= cyc) begin
                total++;
                bad++;
                $display("[TB] FAIL rd_missing: port %0d got vld=0 want vld=1 (cycle %0d)", sbq[k].port, cyc);
                sbq.delete(k);
            end
        end
    end

    function automatic vec_t mkVec(input logic cv, input logic [2:0][9:0] madr, input logic [7:0][1:0] asel,
                                   input logic we, input logic [2:0] wsel, input logic [1:0] rreq,
                                   input logic [1:0][2:0] rsel, input logic clr, input logic [7:0][9:0] expAdr,
                                   input logic [7:0] expEn, input logic [7:0] expWe, input logic expErr);
        vec_t r;
        r.cv = cv; r.madr = madr; r.asel = asel; r.we = we; r.wsel = wsel;
        r.rreq = rreq; r.rsel = rsel; r.clr = clr;
        r.expAdr = expAdr; r.expEn = expEn; r.expWe = expWe; r.expErr = expErr;
        return r;
    endfunction

    // Drive one cycle of inputs, record the reads it should produce, and step past the next edge
    task automatic applyStimulus(input vec_t s, input logic rstVal);
        int src;
        logic [9:0] a;
        rst           = rstVal;
        bus.cmd_valid = s.cv;
        bus.math_adr  = s.madr;
        bus.adr_sel   = s.asel;
        bus.math_we   = s.we;
        bus.we_sel    = s.wsel;
        bus.rd_req    = s.rreq;
        bus.rd_sel    = s.rsel;
        bus.err_clr   = s.clr;
        if (rstVal) begin
            for (int k = sbq.size() - 1; k >= 0; k--) begin
                if (sbq[k].due > cyc) sbq.delete(k);
            end
        end else if (s.cv) begin
            for (int p = 0; p < NP; p++) begin
                if (s.rreq[p]) begin
                    src = int'(s.rsel[p]);
                    a = '0;
                    if (int'(s.asel[src]) < NS) a = s.madr[s.asel[src]];
                    sbq.push_back('{due: cyc + LAT + 2, port: p, data: expWord(src, a)});
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input vec_t s);
        checkVal("bram_adr", bus.bram_adr, s.expAdr);
        checkVal("bram_en", bus.bram_en, s.expEn);
        checkVal("bram_we", bus.bram_we, s.expWe);
        checkVal("err_conflict", bus.err_conflict, s.expErr);
    endtask

    task automatic checkAllZero();
        checkVal("rst_bram_adr", bus.bram_adr, 0);
        checkVal("rst_bram_en", bus.bram_en, 0);
        checkVal("rst_bram_we", bus.bram_we, 0);
        checkVal("rst_math_dat", bus.math_dat, 0);
        checkVal("rst_math_vld", bus.math_dat_vld, 0);
        checkVal("rst_err", bus.err_conflict, 0);
    endtask

    function automatic vec_t readVec(input logic [9:0] a0, input logic [1:0] rreq, input logic [2:0] s1, input logic [2:0] s0);
        vec_t r;
        r = '0;
        r.cv = 1'b1;
        r.madr = {10'h000, 10'h000, a0};
        r.rreq = rreq;
        r.rsel = {s1, s0};
        return r;
    endfunction

    initial begin
        vec_t idle;
        vec_t act;
        idle = '0;

        vecs[0] = mkVec(1'b1, {10'h300, 10'h200, 10'h100},
                        {2'd3, 2'd2, 2'd1, 2'd0, 2'd3, 2'd2, 2'd1, 2'd0},
                        1'b0, 3'd0, 2'b00, {3'd0, 3'd0}, 1'b0,
                        {10'h000, 10'h300, 10'h200, 10'h100, 10'h000, 10'h300, 10'h200, 10'h100},
                        8'h77, 8'h00, 1'b0);
        vecs[1] = mkVec(1'b0, {10'h3ff, 10'h3ff, 10'h3ff}, '0,
                        1'b1, 3'd2, 2'b11, {3'd2, 3'd2}, 1'b0,
                        {10'h000, 10'h300, 10'h200, 10'h100, 10'h000, 10'h300, 10'h200, 10'h100},
                        8'h00, 8'h00, 1'b0);
        vecs[2] = mkVec(1'b1, {10'h123, 10'h045, 10'h3a0},
                        {2'd3, 2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3},
                        1'b1, 3'd6, 2'b00, {3'd0, 3'd0}, 1'b0,
                        {10'h000, 10'h045, 10'h123, 10'h000, 10'h000, 10'h000, 10'h000, 10'h000},
                        8'h60, 8'h40, 1'b0);
        vecs[3] = mkVec(1'b1, {10'h123, 10'h045, 10'h3a0},
                        {2'd3, 2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3},
                        1'b1, 3'd0, 2'b00, {3'd0, 3'd0}, 1'b0,
                        {10'h000, 10'h045, 10'h123, 10'h000, 10'h000, 10'h000, 10'h000, 10'h000},
                        8'h61, 8'h01, 1'b1);
        vecs[4] = mkVec(1'b0, '0, '0, 1'b0, 3'd0, 2'b00, {3'd0, 3'd0}, 1'b1,
                        {10'h000, 10'h045, 10'h123, 10'h000, 10'h000, 10'h000, 10'h000, 10'h000},
                        8'h00, 8'h00, 1'b0);
        vecs[5] = mkVec(1'b1, {10'h111, 10'h222, 10'h333}, '0,
                        1'b1, 3'd3, 2'b10, {3'd3, 3'd0}, 1'b1,
                        {8{10'h333}}, 8'hff, 8'h08, 1'b1);
        vecs[6] = mkVec(1'b0, '0, '0, 1'b0, 3'd0, 2'b00, {3'd0, 3'd0}, 1'b0,
                        {8{10'h333}}, 8'h00, 8'h00, 1'b1);
        vecs[7] = mkVec(1'b0, '0, '0, 1'b0, 3'd0, 2'b00, {3'd0, 3'd0}, 1'b1,
                        {8{10'h333}}, 8'h00, 8'h00, 1'b0);

        // reset with every input active, then one quiet cycle after release
        act = mkVec(1'b1, {10'h3ff, 10'h2aa, 10'h155}, '0, 1'b1, 3'd1, 2'b11, {3'd1, 3'd1}, 1'b1,
                    '0, '0, '0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(act, 1'b1);
            @(negedge clk);
            checkAllZero();
        end
        applyStimulus(idle, 1'b0);
        @(negedge clk);
        checkAllZero();

        // control output vectors
        for (int k = 0; k < 8; k++) begin
            applyStimulus(vecs[k], 1'b0);
            @(negedge clk);
            checkOutput(vecs[k]);
        end
        for (int k = 0; k < LAT + 3; k++) applyStimulus(idle, 1'b0);

        // read latency with both ports on the same BRAM
        applyStimulus(readVec(10'h055, 2'b11, 3'd5, 3'd5), 1'b0);
        applyStimulus(idle, 1'b0);
        applyStimulus(idle, 1'b0);
        @(negedge clk);
        checkVal("lat_vld", bus.math_dat_vld, 2'b11);
        checkVal("lat_dat", bus.math_dat, {expWord(5, 10'h055), expWord(5, 10'h055)});
        applyStimulus(idle, 1'b0);
        @(negedge clk);
        checkVal("lat_vld_off", bus.math_dat_vld, 2'b00);
        checkVal("lat_dat_hold", bus.math_dat, {expWord(5, 10'h055), expWord(5, 10'h055)});

        // back-to-back reads over every BRAM
        for (int k = 0; k < NB; k++) begin
            applyStimulus(readVec(10'h0ab, 2'b11, 3'(NB - 1 - k), 3'(k)), 1'b0);
        end
        for (int k = 0; k < LAT + 3; k++) applyStimulus(idle, 1'b0);

        // reset while a read is in flight, then read on the first edge after release
        applyStimulus(readVec(10'h022, 2'b01, 3'd0, 3'd2), 1'b0);
        applyStimulus(readVec(10'h022, 2'b01, 3'd0, 3'd2), 1'b1);
        applyStimulus(readVec(10'h066, 2'b01, 3'd0, 3'd6), 1'b0);
        @(negedge clk);
        checkVal("flight_vld_a", bus.math_dat_vld, 2'b00);
        applyStimulus(idle, 1'b0);
        @(negedge clk);
        checkVal("flight_vld_b", bus.math_dat_vld, 2'b00);
        applyStimulus(idle, 1'b0);
        @(negedge clk);
        checkVal("release_vld", bus.math_dat_vld, 2'b01);
        checkVal("release_dat", bus.math_dat[DW-1:0], expWord(6, 10'h066));

        // write colliding with a read: flag stays set until a clear pulse
        v = readVec(10'h044, 2'b10, 3'd3, 3'd0);
        v.we = 1'b1;
        v.wsel = 3'd3;
        applyStimulus(v, 1'b0);
        @(negedge clk);
        checkVal("conf_we", bus.bram_we, 8'h08);
        checkVal("conf_err_set", bus.err_conflict, 1'b1);
        applyStimulus(idle, 1'b0);
        applyStimulus(idle, 1'b0);
        @(negedge clk);
        checkVal("conf_err_sticky", bus.err_conflict, 1'b1);
        v = idle;
        v.clr = 1'b1;
        applyStimulus(v, 1'b0);
        @(negedge clk);
        checkVal("conf_err_clr", bus.err_conflict, 1'b0);

        for (int k = 0; k < LAT + 4; k++) applyStimulus(idle, 1'b0);
        checkVal("sb_empty", sbq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
